// File: rtl/uart_fifo_ctrl.sv
// UART controller: bit-level TX/RX engines with a FIFO per direction.
// Optional internal loopback is built only when UART_LOOPBACK_EN is defined.
module uart_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CNTW-1:0]  count_reg;
  logic             do_push, do_pop;

  assign full    = (count_reg == CNTW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // First-word fall-through: the head entry is always visible
  assign rdata   = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CNTW'(do_push) - CNTW'(do_pop);
    end
  end
endmodule

module uart_fifo_ctrl #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_pin,
  output logic                 tx_pin,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 tx_busy,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overflow,
  input  logic                 loopback
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic PAR_EN  = (PARITY != 0);
  localparam logic PAR_ODD = (PARITY == 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  // TX path
  tx_state_t            tx_state_reg;
  logic [CW-1:0]        tx_cnt_reg;
  logic [IW-1:0]        tx_idx_reg;
  logic [DATA_BITS-1:0] tx_shift_reg;
  logic                 tx_par_reg, tx_pin_reg, tx_line;
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_full, tx_empty, tx_pop;

  uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_valid), .wdata(tx_data), .pop(tx_pop),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  assign tx_ready = ~tx_full;
  assign tx_busy  = ~tx_empty | (tx_state_reg != TX_IDLE);
  assign tx_pop   = ~tx_empty & ((tx_state_reg == TX_IDLE) |
                    ((tx_state_reg == TX_STOP) & (tx_cnt_reg == BIT_LAST)));

  always_comb begin
    tx_line = 1'b1;
    case (tx_state_reg)
      TX_START:  tx_line = 1'b0;
      TX_DATA:   tx_line = tx_shift_reg[0];
      TX_PARITY: tx_line = tx_par_reg;
      default:   tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_idx_reg   <= '0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      tx_pin_reg   <= 1'b1;
    end else begin
      // Line is the state decode delayed one cycle, so every bit keeps full length
      tx_pin_reg <= tx_line;
      if (tx_pop) begin
        tx_shift_reg <= tx_head;
        tx_par_reg   <= (^tx_head) ^ PAR_ODD;
        tx_state_reg <= TX_START;
        tx_cnt_reg   <= '0;
      end else begin
        case (tx_state_reg)
          TX_START: begin
            tx_cnt_reg <= (tx_cnt_reg == BIT_LAST) ? '0 : tx_cnt_reg + CW'(1);
            if (tx_cnt_reg == BIT_LAST) begin
              tx_idx_reg   <= '0;
              tx_state_reg <= TX_DATA;
            end
          end
          TX_DATA: begin
            tx_cnt_reg <= (tx_cnt_reg == BIT_LAST) ? '0 : tx_cnt_reg + CW'(1);
            if (tx_cnt_reg == BIT_LAST) begin
              tx_shift_reg <= tx_shift_reg >> 1;
              tx_idx_reg   <= tx_idx_reg + IW'(1);
              if (tx_idx_reg == IDX_LAST) tx_state_reg <= PAR_EN ? TX_PARITY : TX_STOP;
            end
          end
          TX_PARITY: begin
            tx_cnt_reg <= (tx_cnt_reg == BIT_LAST) ? '0 : tx_cnt_reg + CW'(1);
            if (tx_cnt_reg == BIT_LAST) tx_state_reg <= TX_STOP;
          end
          TX_STOP: begin
            tx_cnt_reg <= (tx_cnt_reg == BIT_LAST) ? '0 : tx_cnt_reg + CW'(1);
            if (tx_cnt_reg == BIT_LAST) tx_state_reg <= TX_IDLE;
          end
          default: tx_state_reg <= TX_IDLE;
        endcase
      end
    end
  end

  // RX path; synchroniser and edge history reset low so a stuck-low line never starts a frame
  logic [1:0]           rx_sync_reg;
  logic                 rx_prev_reg, rx_in;
  rx_state_t            rx_state_reg;
  logic [CW-1:0]        rx_cnt_reg;
  logic [IW-1:0]        rx_idx_reg;
  logic [DATA_BITS-1:0] rx_shift_reg, rx_head;
  logic                 rx_par_reg, rx_par_ok, rx_stop_sample, rx_push, rx_full, rx_empty;
  logic                 rx_frame_err_reg, rx_parity_err_reg, rx_overflow_reg;

`ifdef UART_LOOPBACK_EN
  assign rx_in  = loopback ? tx_pin_reg : rx_sync_reg[1];
  assign tx_pin = loopback ? 1'b1 : tx_pin_reg;
`else
  logic unused_loopback;
  assign unused_loopback = loopback;
  assign rx_in  = rx_sync_reg[1];
  assign tx_pin = tx_pin_reg;
`endif

  assign rx_par_ok      = ~PAR_EN | (rx_par_reg == ((^rx_shift_reg) ^ PAR_ODD));
  assign rx_stop_sample = (rx_state_reg == RX_STOP) & (rx_cnt_reg == BIT_LAST);
  assign rx_push        = rx_stop_sample & rx_in & rx_par_ok & ~rx_full;

  uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .wdata(rx_shift_reg), .pop(rx_ready),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );

  assign rx_valid      = ~rx_empty;
  assign rx_data       = rx_valid ? rx_head : '0;
  assign rx_frame_err  = rx_frame_err_reg;
  assign rx_parity_err = rx_parity_err_reg;
  assign rx_overflow   = rx_overflow_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync_reg       <= 2'b00;
      rx_prev_reg       <= 1'b0;
      rx_state_reg      <= RX_IDLE;
      rx_cnt_reg        <= '0;
      rx_idx_reg        <= '0;
      rx_shift_reg      <= '0;
      rx_par_reg        <= 1'b0;
      rx_frame_err_reg  <= 1'b0;
      rx_parity_err_reg <= 1'b0;
      rx_overflow_reg   <= 1'b0;
    end else begin
      rx_sync_reg       <= {rx_sync_reg[0], rx_pin};
      rx_prev_reg       <= rx_in;
      rx_frame_err_reg  <= 1'b0;
      rx_parity_err_reg <= 1'b0;
      rx_overflow_reg   <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: begin
          if (rx_prev_reg & ~rx_in) begin
            rx_state_reg <= RX_START;
            rx_cnt_reg   <= '0;
          end
        end
        RX_START: begin
          rx_cnt_reg <= (rx_cnt_reg == HALF_LAST) ? '0 : rx_cnt_reg + CW'(1);
          if (rx_cnt_reg == HALF_LAST) begin
            rx_idx_reg   <= '0;
            rx_state_reg <= rx_in ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          rx_cnt_reg <= (rx_cnt_reg == BIT_LAST) ? '0 : rx_cnt_reg + CW'(1);
          if (rx_cnt_reg == BIT_LAST) begin
            rx_shift_reg <= {rx_in, rx_shift_reg[DATA_BITS-1:1]};
            rx_idx_reg   <= rx_idx_reg + IW'(1);
            if (rx_idx_reg == IDX_LAST) rx_state_reg <= PAR_EN ? RX_PARITY : RX_STOP;
          end
        end
        RX_PARITY: begin
          rx_cnt_reg <= (rx_cnt_reg == BIT_LAST) ? '0 : rx_cnt_reg + CW'(1);
          if (rx_cnt_reg == BIT_LAST) begin
            rx_par_reg   <= rx_in;
            rx_state_reg <= RX_STOP;
          end
        end
        RX_STOP: begin
          rx_cnt_reg <= (rx_cnt_reg == BIT_LAST) ? '0 : rx_cnt_reg + CW'(1);
          if (rx_cnt_reg == BIT_LAST) begin
            rx_frame_err_reg  <= ~rx_in;
            rx_parity_err_reg <= ~rx_par_ok;
            rx_overflow_reg   <= rx_in & rx_par_ok & rx_full;
            rx_state_reg      <= rx_in ? RX_IDLE : RX_WAIT_HIGH;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_in) rx_state_reg <= RX_IDLE;
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
Parametrised UART controller with built-in bit-level TX/RX engines and a FIFO per direction.
- User side: valid/ready streams.
- Line side: tx_pin/rx_pin.
- Adds configurable baud divider, word width, parity mode, framing/parity/overflow reporting and buffering, so host logic no longer needs to service every byte on time.

Parameters:
CLKS_PER_BIT, 868, clk cycles per bit (>=4); 868 = 115200 baud at 100 MHz
DATA_BITS, 8, data bits per frame (5..9)
FIFO_DEPTH, 16, entries per FIFO; power of two, >=2
PARITY, 0, 0 none, 1 odd, 2 even

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
rx_pin  in  1  asynchronous serial input, idle high
tx_pin  out  1  serial output, idle high
tx_data  in  DATA_BITS  word to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX FIFO not full
rx_data  out  DATA_BITS  head of RX FIFO (first-word fall-through)
rx_valid  out  1  RX FIFO not empty
rx_ready  in  1  consumer accepts rx_data
tx_busy  out  1  TX FIFO non-empty or frame in progress
rx_frame_err  out  1  one-cycle pulse: stop bit sampled low
rx_parity_err  out  1  one-cycle pulse: parity mismatch
rx_overflow  out  1  one-cycle pulse: received word dropped, RX FIFO full
loopback  in  1  internal loopback request (see Optional Feature)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset: FIFOs emptied; both FSMs to IDLE. Outputs during/after reset:
  - tx_pin=1, tx_ready=1, tx_busy=0
  - rx_valid=0, rx_data=0
  - all error pulses 0
- Reset mid-frame aborts the frame; tx_pin returns high the cycle after the reset edge.
- Handshakes:
  - TX push on edge where tx_valid & tx_ready.
  - RX pop on edge where rx_valid & rx_ready.
  - Push and pop in the same cycle are legal in both FIFOs.
  - Count arithmetic is width log2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
- Frame format: start(0), DATA_BITS data LSB first, optional parity bit, one stop(1). Each bit lasts exactly CLKS_PER_BIT cycles.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE with FIFO non-empty: pop and enter START.
  - Word accepted into an empty FIFO with FSM idle: tx_pin falls on the 2nd clk edge after the accept edge.
  - Back-to-back: if FIFO is non-empty when STOP ends, next START begins on the immediately following cycle (no idle gap).
  - PARITY state is skipped when PARITY=0.
- RX sync: rx_pin passes a 2-flop synchroniser; all RX decisions use the synchronised bit.
- RX FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: falling edge of synchronised line enters START.
  - START: sample at CLKS_PER_BIT/2 (integer divide). If high, glitch: return to IDLE, no error.
  - Subsequent samples every CLKS_PER_BIT cycles (mid-bit).
  - Stop sample 1 with parity OK: push word into RX FIFO in the stop-sample cycle.
  - Stop sample 0: rx_frame_err pulse, word discarded, enter WAIT_HIGH until line reads 1, then IDLE.
  - Parity mismatch with stop OK: rx_parity_err pulse, word discarded.
  - Frame and parity errors together: both pulses assert in the same cycle.
  - RX FIFO full at push time (registered full, before any same-cycle pop): word dropped, rx_overflow pulse.
- Idle line held low after reset: no frame starts until a 1 has been seen.

Optional Feature:
Macro UART_LOOPBACK_EN.
- Defined: when loopback=1, the RX engine input is the internal TX serial signal (bypassing the synchroniser) and tx_pin is forced to 1. Changing loopback mid-frame is allowed; the in-flight frame may error.
- Undefined: loopback is ignored and no loopback mux is built.

Test Plan:
- CLKS_PER_BIT=4, PARITY=0: push 0xA5 -> tx_pin low 2 edges after accept; then 1,0,1,0,0,1,0,1 each 4 cycles; stop 1; tx_busy falls after stop.
- Push 3 words back-to-back -> three contiguous 40-cycle frames, no idle gap; tx_ready stays 1.
- Drive frame 0x3C on rx_pin with rx_ready=0, PARITY=2 (even), parity bit 0 -> rx_valid=1, rx_data=0x3C, no error pulses.
- Same frame with parity bit 1 -> rx_parity_err single pulse, rx_valid stays 0. Stop bit 0 -> rx_frame_err pulse; next good frame received correctly.
- FIFO_DEPTH=4, rx_ready=0, send 5 frames -> first 4 held in order; 5th gives rx_overflow pulse; popping returns original 4.
- With UART_LOOPBACK_EN, loopback=1, push 0x5A -> rx_data=0x5A, tx_pin stays 1 throughout; 1-cycle low pulse on rx_pin -> no frame, no error.
